// File: rtl/raw_block_ram_reader_if.sv
// Bundles the raw RAM read port and the outgoing word stream of the block RAM reader.
// master = reader side, slave = RAM plus stream consumer side.
interface raw_block_ram_reader_if #(
  parameter int abits  = 8,
  parameter int dbytes = 4,
  parameter int blen   = 8
);
  localparam int dbits = dbytes * blen;

  logic [dbytes-1:0] ram_we;
  logic [abits-1:0]  ram_addr;
  logic [dbits-1:0]  ram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [dbits-1:0]  out_data;
  logic              out_last;

  modport master (
    output ram_we, ram_addr, out_valid, out_data, out_last,
    input  ram_rdata, out_ready
  );

  modport slave (
    input  ram_we, ram_addr, out_valid, out_data, out_last,
    output ram_rdata, out_ready
  );
endinterface

// File: rtl/raw_block_ram_reader.sv
// Streams `count` consecutive RAM words from `base_addr` onto a valid/ready stream.
// state   | meaning
// IDLE    | waiting for start
// RUN     | issuing reads and draining the 3-entry FIFO
// FINISH  | one-cycle done pulse, start ignored
module raw_block_ram_reader #(
  parameter int abits  = 8,
  parameter int dbytes = 4,
  parameter int blen   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [abits-1:0]      base_addr,
  input  logic [abits:0]        count,
  output logic                  busy,
  output logic                  done,
  raw_block_ram_reader_if.master bus
);
  localparam int dbits = dbytes * blen;
  localparam logic [abits-1:0] ADDR_ONE = 1;
  localparam logic [abits:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [abits-1:0]  addr_q, addr_d;
  logic [abits:0]    iss_cnt_q, iss_cnt_d;
  logic [abits:0]    dlv_cnt_q, dlv_cnt_d;
  logic              pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  logic [dbits-1:0]  fifo_data_q [3];
  logic [dbits-1:0]  fifo_data_d [3];
  logic [2:0]        fifo_last_q, fifo_last_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       issue;
  logic       push;
  logic       pop;
  logic [2:0] fill;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    iss_cnt_d   = iss_cnt_q;
    dlv_cnt_d   = dlv_cnt_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    // The in-flight read is counted so a word arriving next cycle always has a slot.
    fill  = 3'(fifo_cnt_q) + 3'(pend_q);
    issue = (state_q == S_RUN) && (iss_cnt_q != '0) && (fill <= 3'd2);
    push  = pend_q;
    pop   = (fifo_cnt_q != '0) && bus.out_ready;

    pend_d      = issue;
    pend_last_d = issue && (iss_cnt_q == CNT_ONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          iss_cnt_d = count;
          dlv_cnt_d = count;
          state_d   = (count == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d    = addr_q + ADDR_ONE;
          iss_cnt_d = iss_cnt_q - CNT_ONE;
        end
        if (pop) begin
          dlv_cnt_d = dlv_cnt_q - CNT_ONE;
          if (dlv_cnt_q == CNT_ONE) state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ram_rdata;
      fifo_last_d[wr_ptr_q] = pend_last_q;
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      iss_cnt_q   <= '0;
      dlv_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      for (int i = 0; i < 3; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_cnt_q   <= iss_cnt_d;
      dlv_cnt_q   <= dlv_cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.ram_we    = '0;
  assign bus.ram_addr  = addr_q;
  assign bus.out_valid = (fifo_cnt_q != '0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_raw_block_ram_reader.sv
// Bench for raw_block_ram_reader: RAM model plus a queue of expected words built
// from base/count arithmetic, with fixed, wrap, zero-length, reset and random transfers.
module tb_raw_block_ram_reader;
  localparam int ABITS  = 8;
  localparam int DBYTES = 4;
  localparam int BLEN   = 8;
  localparam int DBITS  = DBYTES * BLEN;
  localparam int DEPTH  = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ABITS-1:0] base_addr = '0;
  logic [ABITS:0]   count = '0;
  logic             busy;
  logic             done;

  raw_block_ram_reader_if #(.abits(ABITS), .dbytes(DBYTES), .blen(BLEN)) bus ();

  raw_block_ram_reader #(.abits(ABITS), .dbytes(DBYTES), .blen(BLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

  bit we_seen = 1'b0;
  always @(negedge clk) if (bus.ram_we !== '0) we_seen = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; called just after a rising edge or at a falling edge.
  task automatic run_xfer(input logic [ABITS-1:0] b, input int n,
                          input bit rnd_ready, input bit poke_start);
    logic [DBITS-1:0] exp_q [$];
    int done_k  = -1;
    int first_k = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
    start     = 1'b1;
    base_addr = b;
    count     = (ABITS+1)'(n);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 4 * n + 40; k++) begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && k == 2) begin
        start     = 1'b1;
        base_addr = ABITS'($urandom);
        count     = (ABITS+1)'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 1) begin
        check("busy_t1", busy, n != 0);
        if (n != 0) check("addr_t1", bus.ram_addr, b);
      end
      if (bus.out_valid) begin
        if (first_k < 0) first_k = k;
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          check("data", bus.out_data, exp_q[0]);
          check("last", bus.out_last, exp_q.size() == 1);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_k = k;
        check("busy_at_done", busy, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_seen", done_k > 0, 1);
    check("words_left", exp_q.size(), 0);
    if (!rnd_ready) begin
      check("first_valid", first_k, (n == 0) ? -1 : 3);
      check("done_cycle", done_k, (n == 0) ? 1 : n + 3);
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_valid", bus.out_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DBITS'(i + 'h100);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_we", bus.ram_we, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xfer(8'd4, 5, 1'b0, 1'b0);
    run_xfer(8'd4, 5, 1'b1, 1'b1);
    run_xfer(8'hFE, 4, 1'b0, 1'b0);
    run_xfer(8'd0, 0, 1'b0, 1'b0);

    // Abort after two of six words have been handed over.
    start = 1'b1; base_addr = 8'h10; count = (ABITS+1)'(6); bus.out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_data", bus.out_data, 'h112);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_addr", bus.ram_addr, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_data", bus.out_data, 0);
    check("abort_last", bus.out_last, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
    end
    run_xfer(8'h20, 6, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = DBITS'($urandom);
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 12);
      run_xfer(ABITS'($urandom), n, 1'($urandom_range(0, 1)),
               (n != 0) && ($urandom_range(0, 1) == 1));
    end
    run_xfer(ABITS'($urandom), 260, 1'b1, 1'b0);
    run_xfer(ABITS'($urandom), 258, 1'b0, 1'b0);

    check("ram_we_never", we_seen, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
